player_action_fsm: RTL and testbench

//   Per-player action state machine, generalised to NUM_ATTACKS attack types with per-attack

---
 rtl/player_action_fsm.sv | 149 ++++++++++++++
 tb/tb_player_action_fsm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/player_action_fsm.sv
// Per-player action state machine: idle/move/jump/attack/hitstun sequencing on frame ticks,
// with per-attack frame lengths, refreshable hitstun and a single-entry attack input buffer.
module player_action_fsm #(
    parameter int                            NUM_ATTACKS = 2,
    parameter int                            CNT_W       = 8,
    parameter logic [NUM_ATTACKS*CNT_W-1:0]  ATK_LEN     = {8'd12, 8'd6},
    parameter logic [CNT_W-1:0]              JUMP_LEN    = 8'd20,
    parameter logic [CNT_W-1:0]              HITSTUN_LEN = 8'd15,
    parameter int                            BUF_FRAMES  = 4,
    localparam int                           AID_W       = (NUM_ATTACKS > 1) ? $clog2(NUM_ATTACKS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   SCEN,
    input  logic                   move_left,
    input  logic                   move_right,
    input  logic                   jump,
    input  logic [NUM_ATTACKS-1:0] attack_req,
    input  logic                   hit_in,
    output logic [2:0]             state,
    output logic                   move_enable,
    output logic                   attack_enable,
    output logic [AID_W-1:0]       attack_id,
    output logic                   attack_start,
    output logic                   jump_start,
    output logic                   facing,
    output logic [CNT_W-1:0]       frame_cnt
);
    // state   | meaning
    // IDLE    | standing, decision every frame tick
    // MOVE    | walking in one direction, decision every frame tick
    // JUMP    | timed airborne phase, attacks only buffered
    // ATTACK  | timed attack, new requests only buffered
    // HITSTUN | timed stun after a hit, refreshed by further hits

    localparam int AGE_W = (BUF_FRAMES > 0) ? $clog2(BUF_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE    = 3'd1,
        S_JUMP    = 3'd2,
        S_ATTACK  = 3'd3,
        S_HITSTUN = 3'd4
    } state_t;

    state_t                 st;
    logic [NUM_ATTACKS-1:0] req_prev;
    logic [NUM_ATTACKS-1:0] req_rise;
    logic [AID_W-1:0]       buf_id;
    logic [AGE_W-1:0]       buf_age;

    state_t                 dec_state;
    logic [AID_W-1:0]       dec_id;
    logic [CNT_W-1:0]       dec_cnt;
    logic                   dec_facing;

    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    function automatic logic [AID_W-1:0] low_idx(input logic [NUM_ATTACKS-1:0] v);
        logic [AID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_ATTACKS - 1; i >= 0; i--)
            if (v[i]) idx = AID_W'(i);
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] atk_len_m1(input logic [AID_W-1:0] id);
        logic [CNT_W-1:0] len;
        len = '0;
        for (int i = 0; i < NUM_ATTACKS; i++)
            if (id == AID_W'(i)) len = ATK_LEN[i*CNT_W +: CNT_W];
        return len_m1(len);
    endfunction

    assign req_rise = attack_req & ~req_prev;
    assign state    = st;

    // Shared priority table: used from IDLE/MOVE and when a timed state expires.
    always_comb begin
        dec_state  = S_IDLE;
        dec_id     = attack_id;
        dec_cnt    = '0;
        dec_facing = facing;
        if (hit_in) begin
            dec_state = S_HITSTUN;
            dec_cnt   = len_m1(HITSTUN_LEN);
        end else if ((|attack_req) || (buf_age != '0)) begin
            dec_state = S_ATTACK;
            dec_id    = (|attack_req) ? low_idx(attack_req) : buf_id;
            dec_cnt   = atk_len_m1(dec_id);
        end else if (jump) begin
            dec_state = S_JUMP;
            dec_cnt   = len_m1(JUMP_LEN);
        end else if (move_left ^ move_right) begin
            dec_state  = S_MOVE;
            dec_facing = move_left;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= S_IDLE;
            move_enable   <= 1'b1;
            attack_enable <= 1'b0;
            attack_id     <= '0;
            attack_start  <= 1'b0;
            jump_start    <= 1'b0;
            facing        <= 1'b0;
            frame_cnt     <= '0;
            req_prev      <= '0;
            buf_id        <= '0;
            buf_age       <= '0;
        end else begin
            attack_start <= 1'b0;
            jump_start   <= 1'b0;
            if (SCEN) begin
                req_prev <= attack_req;
                if (buf_age != '0)
                    buf_age <= buf_age - AGE_W'(1);
                if ((BUF_FRAMES > 0) && (st == S_JUMP || st == S_ATTACK) && (|req_rise)) begin
                    buf_id  <= low_idx(req_rise);
                    buf_age <= AGE_W'(BUF_FRAMES);
                end
                if (hit_in || st == S_IDLE || st == S_MOVE || frame_cnt == '0) begin
                    st            <= dec_state;
                    frame_cnt     <= dec_cnt;
                    facing        <= dec_facing;
                    move_enable   <= (dec_state == S_IDLE) || (dec_state == S_MOVE) ||
                                     (dec_state == S_JUMP);
                    attack_enable <= (dec_state == S_ATTACK);
                    if (dec_state == S_ATTACK) begin
                        attack_id    <= dec_id;
                        attack_start <= 1'b1;
                        buf_age      <= '0;
                    end
                    if (dec_state == S_JUMP)
                        jump_start <= 1'b1;
                    if (dec_state == S_HITSTUN)
                        buf_age <= '0;
                end else begin
                    frame_cnt <= frame_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_player_action_fsm.sv
// Directed self-checking bench for player_action_fsm with hand-computed expectations.
module tb_player_action_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SCEN = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       jump = 1'b0;
    logic [1:0] attack_req = 2'b00;
    logic       hit_in = 1'b0;
    logic [2:0] state;
    logic       move_enable;
    logic       attack_enable;
    logic [0:0] attack_id;
    logic       attack_start;
    logic       jump_start;
    logic       facing;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int starts_before;

    player_action_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .SCEN          (SCEN),
        .move_left     (move_left),
        .move_right    (move_right),
        .jump          (jump),
        .attack_req    (attack_req),
        .hit_in        (hit_in),
        .state         (state),
        .move_enable   (move_enable),
        .attack_enable (attack_enable),
        .attack_id     (attack_id),
        .attack_start  (attack_start),
        .jump_start    (jump_start),
        .facing        (facing),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (attack_start) n_starts++;

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick: SCEN high for one clk, every 4 clk; returns one clk after the deciding edge.
    task automatic tick();
        repeat (3) @(negedge clk);
        SCEN = 1'b1;
        @(negedge clk);
        SCEN = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_move_en", 32'(move_enable), 1);
        chk("rst_atk_en", 32'(attack_enable), 0);
        chk("rst_atk_id", 32'(attack_id), 0);
        chk("rst_pulses", 32'({attack_start, jump_start}), 0);
        chk("rst_facing", 32'(facing), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        reset = 1'b0;

        tick();
        chk("idle_hold", 32'(state), 0);

        // attack 0 from IDLE: 6 frames
        attack_req = 2'b01;
        tick();
        chk("a0_state", 32'(state), 3);
        chk("a0_id", 32'(attack_id), 0);
        chk("a0_start", 32'(attack_start), 1);
        chk("a0_cnt", 32'(frame_cnt), 5);
        chk("a0_enables", 32'({move_enable, attack_enable}), 1);
        @(negedge clk);
        chk("a0_start_drop", 32'(attack_start), 0);
        attack_req = 2'b00;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("a0_countdown", 32'(frame_cnt), 32'(i));
        end
        chk("a0_last_state", 32'(state), 3);
        tick();
        chk("a0_exit_state", 32'(state), 0);
        chk("a0_exit_en", 32'({move_enable, attack_enable}), 2);

        // attack 1 interrupted by hit, then refreshed hitstun
        attack_req = 2'b10;
        tick();
        chk("a1_state", 32'(state), 3);
        chk("a1_id", 32'(attack_id), 1);
        chk("a1_cnt", 32'(frame_cnt), 11);
        attack_req = 2'b00;
        ticks(2);
        hit_in = 1'b1;
        tick();
        hit_in = 1'b0;
        chk("hit_state", 32'(state), 4);
        chk("hit_cnt", 32'(frame_cnt), 14);
        chk("hit_en", 32'({move_enable, attack_enable}), 0);
        ticks(4);
        chk("hit_cnt_dec", 32'(frame_cnt), 10);
        hit_in = 1'b1;
        tick();
        hit_in = 1'b0;
        chk("hit_refresh", 32'(frame_cnt), 14);
        ticks(14);
        chk("hit_last", 32'({state, frame_cnt}), 32'({3'd4, 8'd0}));
        tick();
        chk("hit_exit", 32'(state), 0);
        chk("hit_exit_men", 32'(move_enable), 1);

        // jump, attack 1 requested late in the jump, taken on the exit frame
        jump = 1'b1;
        tick();
        jump = 1'b0;
        chk("j_state", 32'(state), 2);
        chk("j_start", 32'(jump_start), 1);
        chk("j_cnt", 32'(frame_cnt), 19);
        chk("j_men", 32'(move_enable), 1);
        @(negedge clk);
        chk("j_start_drop", 32'(jump_start), 0);
        ticks(17);
        chk("j_cnt2", 32'(frame_cnt), 2);
        attack_req = 2'b10;
        tick();
        chk("j_no_attack", 32'(state), 2);
        tick();
        chk("j_cnt0", 32'(frame_cnt), 0);
        tick();
        chk("j_exit_state", 32'(state), 3);
        chk("j_exit_id", 32'(attack_id), 1);
        chk("j_exit_start", 32'(attack_start), 1);
        chk("j_exit_cnt", 32'(frame_cnt), 11);
        attack_req = 2'b00;
        ticks(12);
        chk("j_atk_done", 32'(state), 0);

        // request buffered during attack 0, consumed on its exit
        attack_req = 2'b01;
        tick();
        attack_req = 2'b00;
        ticks(4);
        chk("b_cnt1", 32'(frame_cnt), 1);
        attack_req = 2'b10;
        tick();
        attack_req = 2'b00;
        chk("b_still_a0", 32'({state, attack_id}), 32'({3'd3, 1'b0}));
        tick();
        chk("b_take_state", 32'(state), 3);
        chk("b_take_id", 32'(attack_id), 1);
        chk("b_take_start", 32'(attack_start), 1);
        chk("b_take_cnt", 32'(frame_cnt), 11);
        ticks(12);
        chk("b_done", 32'(state), 0);

        // buffered request ages out during jump; facing frozen while airborne
        jump = 1'b1;
        tick();
        jump = 1'b0;
        attack_req = 2'b01;
        tick();
        attack_req = 2'b00;
        chk("age_cnt", 32'(frame_cnt), 18);
        starts_before = n_starts;
        ticks(10);
        move_left = 1'b1;
        tick();
        chk("age_facing_frozen", 32'({state, facing}), 32'({3'd2, 1'b0}));
        ticks(7);
        chk("age_cnt0", 32'(frame_cnt), 0);
        tick();
        chk("age_exit_state", 32'(state), 1);
        chk("age_exit_facing", 32'(facing), 1);
        chk("age_no_start", 32'(n_starts), 32'(starts_before));
        chk("age_id_kept", 32'(attack_id), 1);

        // both directions -> IDLE, facing kept; then right alone
        move_right = 1'b1;
        tick();
        chk("lr_state", 32'(state), 0);
        chk("lr_facing", 32'(facing), 1);
        move_left = 1'b0;
        tick();
        chk("r_state", 32'(state), 1);
        chk("r_facing", 32'(facing), 0);

        // no SCEN for 20 clk: everything holds despite input activity
        move_left = 1'b1;
        move_right = 1'b0;
        attack_req = 2'b01;
        jump = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_state", 32'(state), 1);
        chk("hold_facing", 32'(facing), 0);
        chk("hold_en", 32'({move_enable, attack_enable}), 2);
        chk("hold_cnt", 32'(frame_cnt), 0);
        attack_req = 2'b00;
        jump = 1'b0;
        move_left = 1'b0;

        // hit from MOVE, then async reset mid-HITSTUN
        hit_in = 1'b1;
        tick();
        hit_in = 1'b0;
        chk("mh_state", 32'(state), 4);
        chk("mh_cnt", 32'(frame_cnt), 14);
        tick();
        chk("mh_cnt2", 32'(frame_cnt), 13);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_men", 32'(move_enable), 1);
        chk("ar_cnt", 32'(frame_cnt), 0);
        chk("ar_aen", 32'(attack_enable), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
